// File: rtl/mat_rd_prefetch.sv
// mat_rd_prefetch
//   Sequential read prefetcher sitting between the GSIM solver and the
//   matrix memory. The solver sees an in-order, single-beat memory; behind
//   it a small buffer holds words fetched ahead at ascending addresses.
//   A non-sequential read flushes the buffer and marks every response still
//   in flight as stale so it is dropped on arrival.
//
//   Bookkeeping model:
//     - tag FIFO holds the address of every issued, not yet answered read,
//       including the stale ones; the oldest drop_cnt entries are stale.
//     - buffer FIFO holds {tag, data} of answered, not yet consumed reads.
//     - occupancy = buffered + in flight, bounded by DEPTH.
module mat_rd_prefetch #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              s_rreq,
   input  logic [ADDR_W-1:0] s_addr,
   output logic              s_rrdy,
   output logic [DATA_W-1:0] s_dout,
   output logic              s_dout_vld,
   output logic              m_rreq,
   output logic [ADDR_W-1:0] m_addr,
   input  logic              m_rrdy,
   input  logic [DATA_W-1:0] m_dout,
   input  logic              m_dout_vld
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   // Classification of a solver accept, decided on the accept cycle.
   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_HIT,
      ACC_PEND,
      ACC_MISS
   } acc_e;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] buf_tag  [DEPTH];
   logic [DATA_W-1:0] buf_data [DEPTH];
   logic [PTR_W-1:0]  buf_rd;
   logic [PTR_W-1:0]  buf_wr;
   logic [CNT_W-1:0]  buf_cnt;

   logic [ADDR_W-1:0] tag_mem  [DEPTH];
   logic [PTR_W-1:0]  tag_rd;
   logic [PTR_W-1:0]  tag_wr;
   logic [CNT_W-1:0]  tag_cnt;

   logic [CNT_W-1:0]  drop_cnt;
   logic [ADDR_W-1:0] pf_addr;
   logic              pf_stop;
   logic              pend;
   logic [ADDR_W-1:0] pend_addr;

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [CNT_W:0]    occ;
   logic              accept;
   logic              issue;
   acc_e              acc;
   logic [PTR_W-1:0]  live_ptr;
   logic              live_vld;
   logic              rsp;
   logic              rsp_drop;
   logic              rsp_live;
   logic              rsp_fwd;
   logic              rsp_push;
   logic [ADDR_W-1:0] rsp_tag;
   logic              hit_pop;
   logic [CNT_W-1:0]  tag_cnt_nxt;
   logic [PTR_W-1:0]  buf_wr_nxt;

   // Interface handshakes depend on registered state only.
   assign occ    = {1'b0, buf_cnt} + {1'b0, tag_cnt};
   assign s_rrdy = !pend;
   assign m_rreq = !pf_stop && (occ < (CNT_W + 1)'(DEPTH));
   assign m_addr = pf_addr;
   assign accept = s_rreq && s_rrdy;
   assign issue  = m_rreq && m_rrdy;

   // Oldest in-flight entry that is not stale (only meaningful if live_vld).
   assign live_ptr = tag_rd + drop_cnt[PTR_W-1:0];
   assign live_vld = tag_cnt > drop_cnt;

   // Classify the solver accept against the pre-update state.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      acc = ACC_NONE;
      if (accept) begin
         if ((buf_cnt != '0) && (buf_tag[buf_rd] == s_addr)) begin
            acc = ACC_HIT;
         end else if ((buf_cnt == '0) && live_vld && (tag_mem[live_ptr] == s_addr)) begin
            acc = ACC_PEND;
         end else begin
            acc = ACC_MISS;
         end
      end
   end

   // Route an arriving memory response: drop, forward to solver, or buffer.
   always_comb begin
      rsp      = m_dout_vld && (tag_cnt != '0);
      rsp_drop = rsp && (drop_cnt != '0);
      rsp_live = rsp && (drop_cnt == '0);
      rsp_tag  = tag_mem[tag_rd];
      // A pending-hit accept whose word lands in the same cycle is answered
      // straight away; otherwise the word would go to the buffer while pend
      // waits for it in flight.
      rsp_fwd  = rsp_live && ((pend && (rsp_tag == pend_addr)) || (acc == ACC_PEND));
      rsp_push = rsp_live && !rsp_fwd;
      hit_pop  = (acc == ACC_HIT);

      tag_cnt_nxt = tag_cnt + CNT_W'(issue) - CNT_W'(rsp);
      buf_wr_nxt  = buf_wr + PTR_W'(rsp_push);
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   // Pointer, counter, prefetch and pending-request bookkeeping.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tag_rd    <= '0;
         tag_wr    <= '0;
         tag_cnt   <= '0;
         buf_rd    <= '0;
         buf_wr    <= '0;
         buf_cnt   <= '0;
         drop_cnt  <= '0;
         pf_addr   <= '0;
         pf_stop   <= 1'b1;
         pend      <= 1'b0;
         pend_addr <= '0;
      end else begin
         // In-flight tag FIFO: push on issue, pop on any counted response.
         if (issue) begin
            tag_wr <= tag_wr + PTR_W'(1);
         end
         if (rsp) begin
            tag_rd <= tag_rd + PTR_W'(1);
         end
         tag_cnt <= tag_cnt_nxt;

         // Buffer FIFO: a miss flushes after this cycle's push.
         buf_wr <= buf_wr_nxt;
         if (acc == ACC_MISS) begin
            buf_rd  <= buf_wr_nxt;
            buf_cnt <= '0;
         end else begin
            buf_rd  <= buf_rd + PTR_W'(hit_pop);
            buf_cnt <= buf_cnt + CNT_W'(rsp_push) - CNT_W'(hit_pop);
         end

         // On a miss everything still in flight, including this cycle's
         // issue, becomes stale.
         if (acc == ACC_MISS) begin
            drop_cnt <= tag_cnt_nxt;
         end else begin
            drop_cnt <= drop_cnt - CNT_W'(rsp_drop);
         end

         // Prefetch address: restart at the miss address, stop at the top.
         if (acc == ACC_MISS) begin
            pf_addr <= s_addr;
            pf_stop <= 1'b0;
         end else if (issue) begin
            if (pf_addr == ADDR_MAX) begin
               pf_stop <= 1'b1;
            end else begin
               pf_addr <= pf_addr + ADDR_W'(1);
            end
         end

         // A request waits for its word while it is still in flight.
         if ((acc == ACC_MISS) || ((acc == ACC_PEND) && !rsp_live)) begin
            pend      <= 1'b1;
            pend_addr <= s_addr;
         end else if (rsp_fwd) begin
            pend      <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   // Tag and data arrays; written on issue and on buffered responses.
   // NOTE: storage arrays carry no reset; the counters above define which
   // entries are valid, so stale contents are never observed.
   always_ff @(posedge i_clk) begin
      if (issue) begin
         tag_mem[tag_wr] <= pf_addr;
      end
      if (rsp_push) begin
         buf_tag[buf_wr]  <= rsp_tag;
         buf_data[buf_wr] <= m_dout;
      end
   end

   // ---------------------------------------------------------------------
   // Solver read data
   // ---------------------------------------------------------------------
   // Registered read data: a buffer hit or a forwarded memory response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_dout     <= '0;
         s_dout_vld <= 1'b0;
      end else begin
         s_dout_vld <= hit_pop || rsp_fwd;
         if (hit_pop) begin
            s_dout <= buf_data[buf_rd];
         end else if (rsp_fwd) begin
            s_dout <= m_dout;
         end
      end
   end

endmodule

// File: tb/tb_mat_rd_prefetch.sv
// Testbench for mat_rd_prefetch: in-order memory model with configurable
// latency/backpressure, a streaming solver driver and a scoreboard that
// checks data, latency and absence of spurious read data.
`timescale 1ns/1ps
module tb_mat_rd_prefetch;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              s_rreq;
   logic [ADDR_W-1:0] s_addr;
   logic              s_rrdy;
   logic [DATA_W-1:0] s_dout;
   logic              s_dout_vld;
   logic              m_rreq;
   logic [ADDR_W-1:0] m_addr;
   logic              m_rrdy;
   logic [DATA_W-1:0] m_dout;
   logic              m_dout_vld;

   mat_rd_prefetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .s_rreq     (s_rreq),
      .s_addr     (s_addr),
      .s_rrdy     (s_rrdy),
      .s_dout     (s_dout),
      .s_dout_vld (s_dout_vld),
      .m_rreq     (m_rreq),
      .m_addr     (m_addr),
      .m_rrdy     (m_rrdy),
      .m_dout     (m_dout),
      .m_dout_vld (m_dout_vld)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = {6'd0, a};
      return w;
   endfunction

   // ---------------- memory model ----------------
   logic [ADDR_W-1:0] rsp_addr_q[$];
   int                rsp_due_q[$];
   logic [ADDR_W-1:0] issue_log[$];
   int                issue_cnt[1024];
   int                last_due  = 0;
   int                mem_lat   = 3;
   bit                rnd_mode  = 1'b0;
   int                slow_addr = -1;
   int                slow_lat  = 0;
   int                max_out   = 0;

   initial begin : mem_model
      int                inflight;
      int                lat;
      int                due;
      logic [ADDR_W-1:0] a;
      m_rrdy     = 1'b0;
      m_dout     = '0;
      m_dout_vld = 1'b0;
      forever begin
         @(negedge i_clk);
         inflight   = rsp_addr_q.size();
         m_dout_vld = 1'b0;
         if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            a = rsp_addr_q.pop_front();
            void'(rsp_due_q.pop_front());
            m_dout     = mem_word(a);
            m_dout_vld = 1'b1;
         end
         m_rrdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_rreq && m_rrdy) begin
            if (rnd_mode) lat = int'($urandom_range(1, 6));
            else if (int'(m_addr) == slow_addr) lat = slow_lat;
            else lat = mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_addr_q.push_back(m_addr);
            rsp_due_q.push_back(due);
            issue_log.push_back(m_addr);
            issue_cnt[m_addr]++;
            if (inflight + 1 > max_out) max_out = inflight + 1;
         end
      end
   end

   // ---------------- solver driver / scoreboard ----------------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                exp_lat;   // accept cycle to s_dout_vld cycle, -1 = any
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                acc_cyc;
      int                exp_lat;
   } exp_t;

   vec_t cur[$];
   exp_t exp_q[$];

   function automatic vec_t mk(input int a, input int l);
      vec_t v;
      v.addr    = ADDR_W'(a);
      v.exp_lat = l;
      return v;
   endfunction

   task automatic run_reads(input string name, input int budget);
      int   idx;
      int   t;
      exp_t e;
      idx = 0;
      t   = 0;
      exp_q.delete();
      while ((idx < cur.size() || exp_q.size() > 0) && t < budget) begin
         @(negedge i_clk);
         t++;
         if (s_dout_vld && exp_q.size() == 0) begin
            check($sformatf("%s spurious_vld", name), s_dout_vld, 0);
         end else if (s_dout_vld) begin
            e = exp_q.pop_front();
            check($sformatf("%s data@%0d", name, e.addr), s_dout, mem_word(e.addr));
            if (e.exp_lat >= 0)
               check($sformatf("%s latency@%0d", name, e.addr), cyc - e.acc_cyc, e.exp_lat);
         end
         if (s_rrdy && idx < cur.size()) begin
            s_rreq    = 1'b1;
            s_addr    = cur[idx].addr;
            e.addr    = cur[idx].addr;
            e.acc_cyc = cyc;
            e.exp_lat = cur[idx].exp_lat;
            exp_q.push_back(e);
            idx++;
         end else begin
            s_rreq = 1'b0;
         end
      end
      s_rreq = 1'b0;
      check($sformatf("%s reads_left", name), exp_q.size() + (cur.size() - idx), 0);
   endtask

   task automatic idle(input int n, output int vld_seen);
      vld_seen = 0;
      s_rreq   = 1'b0;
      repeat (n) begin
         @(negedge i_clk);
         if (s_dout_vld) vld_seen++;
      end
   endtask

   task automatic drain_reset();
      int t;
      t      = 0;
      s_rreq = 1'b0;
      while (rsp_addr_q.size() > 0 && t < 200) begin
         @(negedge i_clk);
         t++;
      end
      check("drain_inflight", rsp_addr_q.size(), 0);
      @(posedge i_clk);
      #1 i_rst_n = 1'b0;
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      issue_log.delete();
      foreach (issue_cnt[i]) issue_cnt[i] = 0;
      max_out = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " s_rrdy"},     s_rrdy,     1);
      check({tag, " s_dout_vld"}, s_dout_vld, 0);
      check({tag, " s_dout"},     s_dout,     0);
      check({tag, " m_rreq"},     m_rreq,     0);
      check({tag, " m_addr"},     m_addr,     0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main test ----------------
   initial begin : main
      vec_t              seq_tbl[$];
      vec_t              jump_tbl[$];
      vec_t              top_tbl[$];
      vec_t              pend_tbl[$];
      vec_t              bp_tbl[$];
      vec_t              rst_tbl[$];
      int                vld_seen;
      int                k;
      int                n_iss;
      logic [ADDR_W-1:0] nxt1;
      logic [ADDR_W-1:0] nxt2;

      // Stimulus tables with hand-derived latencies (memory latency L gives
      // a miss latency of 1 + L + 1 with nothing to drain).
      for (int a = 0; a < 16; a++) seq_tbl.push_back(mk(a, (a == 0) ? 5 : 1));
      jump_tbl.push_back(mk(0, 5));
      jump_tbl.push_back(mk(1, 1));
      jump_tbl.push_back(mk(2, 1));
      jump_tbl.push_back(mk(40, 5));   // 3 stale responses drain while 40 flies
      top_tbl.push_back(mk(1021, 5));
      top_tbl.push_back(mk(1022, 1));
      top_tbl.push_back(mk(1023, 1));
      pend_tbl.push_back(mk(0, 7));    // latency 5
      pend_tbl.push_back(mk(1, 6));    // word 1 slowed to latency 10
      rst_tbl.push_back(mk(7, 6));     // latency 4
      for (int m = 0; bp_tbl.size() < 200; m++) begin
         bp_tbl.push_back(mk(17 * m + 16, -1));
         for (int o = 15; o >= 1; o--) bp_tbl.push_back(mk(17 * m + o, -1));
         for (int o = 1; o <= 15; o++) bp_tbl.push_back(mk(17 * m + o, -1));
         bp_tbl.push_back(mk(17 * m, -1));
      end
      while (bp_tbl.size() > 200) void'(bp_tbl.pop_back());

      // Reset state.
      s_rreq = 1'b0;
      s_addr = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      i_rst_n = 1'b1;
      idle(4, vld_seen);
      check("reset idle_vld", vld_seen, 0);
      check("reset no_prefetch", issue_log.size(), 0);

      // Sequential reads, latency 3.
      mem_lat = 3;
      cur = seq_tbl;
      run_reads("seq", 400);
      check("seq max_outstanding", max_out, DEPTH);
      drain_reset();

      // Jump after a short sequential run.
      cur = jump_tbl;
      run_reads("jump", 400);
      idle(12, vld_seen);
      check("jump stale_vld", vld_seen, 0);
      k = -1;
      foreach (issue_log[i]) if (issue_log[i] == 40 && k < 0) k = i;
      nxt1 = (k >= 0 && issue_log.size() > k + 1) ? issue_log[k+1] : '1;
      nxt2 = (k >= 0 && issue_log.size() > k + 2) ? issue_log[k+2] : '1;
      check("jump next_addr1", nxt1, 41);
      check("jump next_addr2", nxt2, 42);
      check("jump addr40_once", issue_cnt[40], 1);
      drain_reset();

      // Top of address space.
      cur = top_tbl;
      run_reads("top", 400);
      idle(10, vld_seen);
      check("top idle_vld", vld_seen, 0);
      check("top issue_count", issue_log.size(), 3);
      check("top last_issue", issue_log[issue_log.size()-1], 1023);
      check("top m_rreq_stopped", m_rreq, 0);
      drain_reset();

      // Pending hit: word 1 still in flight when it is requested.
      mem_lat   = 5;
      slow_addr = 1;
      slow_lat  = 10;
      cur = pend_tbl;
      run_reads("pend", 400);
      check("pend addr0_once", issue_cnt[0], 1);
      check("pend addr1_once", issue_cnt[1], 1);
      slow_addr = -1;
      drain_reset();

      // Random backpressure and latency.
      rnd_mode = 1'b1;
      cur = bp_tbl;
      run_reads("bp", 20000);
      drain_reset();
      rnd_mode = 1'b0;

      // Reset with three reads in flight.
      mem_lat = 4;
      @(negedge i_clk);
      s_rreq = 1'b1;
      s_addr = '0;
      @(negedge i_clk);
      s_rreq = 1'b0;
      repeat (2) @(negedge i_clk);
      @(posedge i_clk);
      #1;
      check("rst inflight", rsp_addr_q.size(), 3);
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("rst mid");
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      n_iss = issue_log.size();
      idle(10, vld_seen);
      check("rst late_rsp_vld", vld_seen, 0);
      check("rst no_issue", issue_log.size() - n_iss, 0);
      cur = rst_tbl;
      run_reads("rst", 400);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
